// File: rtl/seg_scan_arbiter.sv
// Four-digit seven-segment scanner shared by two clients through a frame-aligned round-robin arbiter.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_arbiter #(
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        req_a,
  input  logic [15:0] val_a,
  input  logic [3:0]  dp_a,
  input  logic        req_b,
  input  logic [15:0] val_b,
  input  logic [3:0]  dp_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        frame_tick,
  output logic [3:0]  digit,
  output logic [7:0]  seg
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    idx_reg, idx_next;
  logic [1:0]    state_reg, state_next;
  logic [HW-1:0] held_reg, held_next;
  logic          rr_reg, rr_next;
  logic [15:0]   buf_val_reg, buf_val_next;
  logic [3:0]    buf_dp_reg, buf_dp_next;
  logic [3:0]    digit_reg, digit_next;
  logic [7:0]    seg_reg, seg_next;
  logic          gnt_a_reg, gnt_b_reg, frame_tick_reg;
  logic          boundary, hold_done;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // A nibble is a leading zero when it and every nibble above it are zero; nibble 0 always shows.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] i);
    case (i)
      2'd1:    lz_blank = (v[15:4] == 12'h000);
      2'd2:    lz_blank = (v[15:8] == 8'h00);
      2'd3:    lz_blank = (v[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
  endfunction

  assign boundary  = (cnt_reg == CNT_MAX) && (idx_reg == 2'd3);
  assign hold_done = (int'(held_reg) + 1) >= HOLD_FRAMES;

  always_comb begin
    cnt_next     = (cnt_reg == CNT_MAX) ? '0 : cnt_reg + 1'b1;
    idx_next     = (cnt_reg == CNT_MAX) ? idx_reg + 2'd1 : idx_reg;
    state_next   = state_reg;
    held_next    = held_reg;
    rr_next      = rr_reg;
    buf_val_next = buf_val_reg;
    buf_dp_next  = buf_dp_reg;

    if (boundary) begin
      case (state_reg)
        OWN_A: begin
          if (!req_a)
            state_next = req_b ? OWN_B : IDLE;
          else if (req_b && hold_done)
            state_next = OWN_B;
        end
        OWN_B: begin
          if (!req_b)
            state_next = req_a ? OWN_A : IDLE;
          else if (req_a && hold_done)
            state_next = OWN_A;
        end
        default: begin
          if (req_a && req_b)
            state_next = rr_reg ? OWN_B : OWN_A;
          else if (req_a)
            state_next = OWN_A;
          else if (req_b)
            state_next = OWN_B;
        end
      endcase

      if (state_next != state_reg) begin
        held_next = '0;
        if (state_next == OWN_A) rr_next = 1'b1;
        if (state_next == OWN_B) rr_next = 1'b0;
      end else if (state_reg != IDLE && int'(held_reg) < HOLD_FRAMES) begin
        held_next = held_reg + 1'b1;
      end

      case (state_next)
        OWN_A:   begin buf_val_next = val_a; buf_dp_next = dp_a; end
        OWN_B:   begin buf_val_next = val_b; buf_dp_next = dp_b; end
        default: begin buf_val_next = '0;    buf_dp_next = '0;   end
      endcase
    end
  end

  // Display outputs are computed from next-cycle state so they line up with idx and grants.
  always_comb begin
    nibble     = buf_val_next[{idx_next, 2'b00} +: 4];
    digit_next = 4'b0000;
    seg_next   = 8'h00;
    if (state_next != IDLE) begin
      digit_next = 4'b0001 << idx_next;
`ifdef SEG_LZ_BLANK_EN
      seg_next[6:0] = lz_blank(buf_val_next, idx_next) ? 7'h00 : hex_to_seg(nibble);
`else
      seg_next[6:0] = hex_to_seg(nibble);
`endif
      seg_next[7] = buf_dp_next[idx_next];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      state_reg      <= IDLE;
      held_reg       <= '0;
      rr_reg         <= 1'b0;
      buf_val_reg    <= '0;
      buf_dp_reg     <= '0;
      digit_reg      <= '0;
      seg_reg        <= '0;
      gnt_a_reg      <= 1'b0;
      gnt_b_reg      <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      state_reg      <= state_next;
      held_reg       <= held_next;
      rr_reg         <= rr_next;
      buf_val_reg    <= buf_val_next;
      buf_dp_reg     <= buf_dp_next;
      digit_reg      <= digit_next;
      seg_reg        <= seg_next;
      gnt_a_reg      <= (state_next == OWN_A);
      gnt_b_reg      <= (state_next == OWN_B);
      frame_tick_reg <= boundary;
    end
  end

  assign gnt_a      = gnt_a_reg;
  assign gnt_b      = gnt_b_reg;
  assign frame_tick = frame_tick_reg;
  assign digit      = digit_reg;
  assign seg        = seg_reg;

  // lz_blank is only referenced when blanking is built in.
`ifndef SEG_LZ_BLANK_EN
  logic unused_lz;
  assign unused_lz = lz_blank(16'h0000, 2'd0);
`endif

endmodule

// File: doc/seg_scan_arbiter.md
# seg_scan_arbiter

Display controller for the 4-digit seven-segment board display. It time-multiplexes the four digits and decodes each hex nibble to segments. It also shares the display between two client blocks (A, B) through a round-robin, frame-aligned request/grant arbiter. It sits between the application datapaths and the board `seg`/`digit` pins, and replaces per-client direct segment drive.

## Interface
- `SCAN_DIV`, default 100000: clk cycles per digit slot, ≥2.
- `HOLD_FRAMES`, default 8: minimum frames an owner keeps the display while the other side requests, ≥1.

Ports:
- `clk`  in  1  system clock.
- `rstb`  in  1  reset, synchronous, active-low.
- `req_a`  in  1  client A requests display (level).
- `val_a`  in  16  client A hex value; nibble i drives digit i.
- `dp_a`  in  4  client A decimal points; bit i lights digit i.
- `req_b`, `val_b`, `dp_b`: client B, identical to A.
- `gnt_a`  out  1  A owns display (level).
- `gnt_b`  out  1  B owns display (level).
- `frame_tick`  out  1  one-cycle pulse at start of each frame.
- `digit`  out  4  digit enables, active-high, one-hot or all-zero.
- `seg`  out  8  segments, active-high; [0]=a … [6]=g, [7]=dp.

## Operation
- Scan counter `cnt` counts 0..SCAN_DIV-1. Digit index `idx` (0..3) advances when `cnt`=SCAN_DIV-1 and wraps 3→0.
- A frame is idx 0→3. The boundary cycle is `cnt`=SCAN_DIV-1 with idx=3.
- Arbiter states are IDLE, OWN_A, OWN_B. Transitions are evaluated only on the boundary cycle:
  - IDLE: both requests → side selected by the rr pointer (reset value favours A); only one request → that side; none → stay.
  - OWN_X: `req_X` low → other side if it requests, else IDLE.
  - OWN_X: `req_X` high and other side requesting and `held`+1 ≥ HOLD_FRAMES → other side.
  - OWN_X: otherwise stay.
- `held` counts frames completed under the current owner, saturates, and clears on every state change.
- The rr pointer points away from the last owner granted.
- Frame buffer: 16-bit value plus 4-bit dp. On the boundary cycle it loads from the next-state owner. It is frozen for the rest of the frame, so a mid-frame change to `val`/`dp`/`req` never alters the current frame.
- Decode table (hex → seg[6:0]):
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71
  - seg[7] = buffered dp[idx].
- In IDLE: `digit`=0000, `seg`=00. Otherwise `digit`=1<<idx and `seg`=decode(buffer nibble idx).

## Timing
- Reset values: `gnt_a`=`gnt_b`=0, `frame_tick`=0, `digit`=0000, `seg`=00. Also `cnt`=0, `idx`=0, `held`=0, state IDLE, rr→A, buffer 0.
- Reset mid-operation forces all of the above on the next edge and aborts the frame. No partial grant survives.
- All outputs are registered. State, `gnt_*`, buffer, idx=0, `digit`/`seg` and `frame_tick` all update on the edge ending the boundary cycle, so they are visible together in the first cycle of the new frame.
- Latency from a request on an idle display to grant: up to 4·SCAN_DIV cycles, 1 cycle after the next boundary.
- `gnt_a` and `gnt_b` are never both high. A grant lasts whole frames only.
- A requester dropping `req` mid-frame still has its buffered value shown until the boundary. Its grant stays high until then.
- Simultaneous drop by the owner and a new request from the other side at the boundary → other side granted, no IDLE gap.

## Configuration
- `SEG_LZ_BLANK_EN` defined: leading-zero blanking. Scanning from nibble 3 down, each zero nibble above the most-significant nonzero nibble drives seg[6:0]=00. Nibble 0 is never blanked.
- Under blanking, `digit` still strobes and seg[7] still follows dp.
- `SEG_LZ_BLANK_EN` undefined: every nibble is decoded normally (zero → 3F).

## Test plan
Bench parameters for all scenarios: SCAN_DIV=4, HOLD_FRAMES=2.
1. Reset: rstb low 3 cycles in mid-frame with A owning → next cycle all outputs 0, state IDLE. After release the first boundary is at cycle 16.
2. Single client: `req_a`=1, `val_a`=16'h12AF, `dp_a`=4'b0001 → `gnt_a` high after the first boundary. Per-slot results:
   - digit=0001, seg=F1
   - digit=0010, seg=77
   - digit=0100, seg=5B
   - digit=1000, seg=06
3. Contention from IDLE: both request → A is granted. After 2 frames B is granted while `req_a` stays high. After 2 more frames A is granted again. `gnt_a`&`gnt_b` is never high.
4. Mid-frame change: while A owns, change `val_a` from 16'h1111 to 16'h2222 at idx=1 → slots 1–3 still show 06. The next frame shows 5B.
5. Owner drops: `req_a` falls at idx=2 with `req_b`=0 → A's buffer is shown through idx=3, then digit=0000, seg=00, both grants 0.
6. `val_a`=16'h0005, `dp_a`=0: with `SEG_LZ_BLANK_EN`, digits 3..1 give seg=00 and digit 0 gives 6D. Without the macro, digits 3..1 give 3F.
